// File: rtl/kestrel_bus_decoder.sv
// Kestrel data-bus interconnect: one master, NSLAVES address regions, registered
// one-hot slave strobes, a no-ack watchdog and capture of errored accesses.
module kestrel_bus_decoder #(
   parameter int NSLAVES  = 4,
   parameter int SEL_BITS = 2,
   parameter int ADR_W    = 15,
   parameter int DAT_W    = 16,
   parameter int TIMEOUT  = 15,
   parameter int ERRC_W   = 8
) (
   input  logic                      sys_clk_i,
   input  logic                      sys_rst_i,
   input  logic [ADR_W-1:0]          m_adr_i,
   input  logic [DAT_W-1:0]          m_dat_i,
   output logic [DAT_W-1:0]          m_dat_o,
   input  logic                      m_we_i,
   input  logic                      m_cyc_i,
   input  logic                      m_stb_i,
   output logic                      m_ack_o,
   output logic                      m_err_o,
   output logic [ADR_W-SEL_BITS-1:0] s_adr_o,
   output logic [DAT_W-1:0]          s_dat_o,
   output logic                      s_we_o,
   output logic                      s_cyc_o,
   output logic [NSLAVES-1:0]        s_stb_o,
   input  logic [NSLAVES*DAT_W-1:0]  s_dat_i,
   input  logic [NSLAVES-1:0]        s_ack_i,
   output logic [ADR_W-1:0]          err_adr_o,
   output logic [ERRC_W-1:0]         err_cnt_o
);

   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   state_t              r_state;
   logic [SEL_BITS-1:0] r_sel;
   logic [TMR_W-1:0]    r_tmr;
   logic [NSLAVES-1:0]  r_stb;
   logic [DAT_W-1:0]    r_dat;
   logic                r_ack;
   logic                r_err;
   logic [ADR_W-1:0]    r_err_adr;
   logic [ERRC_W-1:0]   r_err_cnt;

   logic [SEL_BITS-1:0] w_region;
   logic                w_mapped;
   logic                w_req;
   logic [NSLAVES-1:0]  w_onehot;
   logic                w_ack_sel;
   logic [DAT_W-1:0]    w_dat_sel;

   assign s_adr_o   = m_adr_i[ADR_W-SEL_BITS-1:0];
   assign s_dat_o   = m_dat_i;
   assign s_we_o    = m_we_i;
   assign s_cyc_o   = m_cyc_i;
   assign s_stb_o   = r_stb;
   assign m_dat_o   = r_dat;
   assign m_ack_o   = r_ack;
   assign m_err_o   = r_err;
   assign err_adr_o = r_err_adr;
   assign err_cnt_o = r_err_cnt;

   assign w_region = m_adr_i[ADR_W-1 -: SEL_BITS];
   assign w_mapped = ({1'b0, w_region} < (SEL_BITS+1)'(NSLAVES));
   assign w_req    = m_cyc_i & m_stb_i;

   // Only the latched slot may complete the access; other acks are masked here.
   always_comb begin
      w_onehot  = '0;
      w_ack_sel = 1'b0;
      w_dat_sel = '0;
      for (int i = 0; i < NSLAVES; i++) begin
         if (w_region == SEL_BITS'(i)) w_onehot[i] = 1'b1;
         if (r_sel == SEL_BITS'(i)) begin
            w_ack_sel = s_ack_i[i];
            w_dat_sel = s_dat_i[i*DAT_W +: DAT_W];
         end
      end
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         r_state   <= ST_IDLE;
         r_sel     <= '0;
         r_tmr     <= '0;
         r_stb     <= '0;
         r_dat     <= '0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_err_adr <= '0;
         r_err_cnt <= '0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  if (w_mapped) begin
                     r_sel   <= w_region;
                     r_tmr   <= '0;
                     r_stb   <= w_onehot;
                     r_state <= ST_WAIT;
                  end else begin
                     r_err     <= 1'b1;
                     r_err_adr <= m_adr_i;
                     if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
                     r_state   <= ST_DONE;
                  end
               end
            end
            ST_WAIT: begin
               // Abort beats ack, ack beats the watchdog.
               if (!m_cyc_i) begin
                  r_stb   <= '0;
                  r_state <= ST_IDLE;
               end else if (w_ack_sel) begin
                  r_dat   <= w_dat_sel;
                  r_ack   <= 1'b1;
                  r_stb   <= '0;
                  r_state <= ST_DONE;
               end else begin
                  r_tmr <= r_tmr + 1'b1;
                  if (TIMEOUT != 0 && r_tmr == TMR_LAST) begin
                     r_err     <= 1'b1;
                     r_stb     <= '0;
                     r_err_adr <= m_adr_i;
                     if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
                     r_state   <= ST_DONE;
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_kestrel_bus_decoder.sv
// Bench for kestrel_bus_decoder: vector table through a scoreboard, plus abort,
// spurious-ack, unmapped-region, saturation and reset-mid-access sequences.
module tb_kestrel_bus_decoder;
   localparam int NS = 4, SB = 2, AW = 15, DW = 16, TO = 15, EW = 8;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0]    m_adr = '0;
   logic [DW-1:0]    m_dat = '0;
   logic             m_we = 1'b0, m_cyc = 1'b0, m_stb = 1'b0;
   logic [DW-1:0]    m_dat_o;
   logic             m_ack, m_err;
   logic [AW-SB-1:0] s_adr;
   logic [DW-1:0]    s_dat;
   logic             s_we, s_cyc;
   logic [NS-1:0]    s_stb, s_ack;
   logic [NS*DW-1:0] s_dat_i;
   logic [AW-1:0]    err_adr;
   logic [EW-1:0]    err_cnt;

   logic             u3_cyc = 1'b0, u3_stb = 1'b0;
   logic [DW-1:0]    u3_dat_o;
   logic             u3_ack, u3_err, u3_we, u3_scyc;
   logic [AW-SB-1:0] u3_sadr;
   logic [DW-1:0]    u3_sdat;
   logic [2:0]       u3_sstb;
   logic [3*DW-1:0]  u3_sdat_i = '0;
   logic [2:0]       u3_sack = '0;
   logic [AW-1:0]    u3_eadr;
   logic [EW-1:0]    u3_ecnt;

   kestrel_bus_decoder #(.NSLAVES(NS), .SEL_BITS(SB), .ADR_W(AW), .DAT_W(DW),
                         .TIMEOUT(TO), .ERRC_W(EW)) u_dut (
      .sys_clk_i(clk), .sys_rst_i(rst_n), .m_adr_i(m_adr), .m_dat_i(m_dat),
      .m_dat_o(m_dat_o), .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
      .m_ack_o(m_ack), .m_err_o(m_err), .s_adr_o(s_adr), .s_dat_o(s_dat),
      .s_we_o(s_we), .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_dat_i(s_dat_i),
      .s_ack_i(s_ack), .err_adr_o(err_adr), .err_cnt_o(err_cnt));

   kestrel_bus_decoder #(.NSLAVES(3), .SEL_BITS(SB), .ADR_W(AW), .DAT_W(DW),
                         .TIMEOUT(TO), .ERRC_W(EW)) u_dut3 (
      .sys_clk_i(clk), .sys_rst_i(rst_n), .m_adr_i(m_adr), .m_dat_i(m_dat),
      .m_dat_o(u3_dat_o), .m_we_i(m_we), .m_cyc_i(u3_cyc), .m_stb_i(u3_stb),
      .m_ack_o(u3_ack), .m_err_o(u3_err), .s_adr_o(u3_sadr), .s_dat_o(u3_sdat),
      .s_we_o(u3_we), .s_cyc_o(u3_scyc), .s_stb_o(u3_sstb), .s_dat_i(u3_sdat_i),
      .s_ack_i(u3_sack), .err_adr_o(u3_eadr), .err_cnt_o(u3_ecnt));

   // Slave model: each slave acks after slv_wait wait states while strobed.
   assign s_dat_i = {16'hD3D3, 16'hC2C2, 16'hBEEF, 16'hA0A0};
   int            slv_wait = 0;
   logic          slv_en = 1'b1;
   logic [NS-1:0] spur = '0;
   int            wcnt [NS];

   always @(posedge clk)
      for (int i = 0; i < NS; i++) wcnt[i] <= s_stb[i] ? wcnt[i] + 1 : 0;

   always_comb begin
      s_ack = spur;
      for (int i = 0; i < NS; i++)
         if (s_stb[i] && slv_en && wcnt[i] == slv_wait) s_ack[i] = 1'b1;
   end

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          ack;
      logic          chkdat;
      logic [DW-1:0] dat;
      logic [AW-1:0] eadr;
      logic [EW-1:0] ecnt;
   } exp_t;

   exp_t          sbq [$];
   exp_t          mon_e;
   logic [EW-1:0] mcnt = '0;

   always @(negedge clk) begin
      if (rst_n && (m_ack || m_err)) begin
         if (sbq.size() == 0) chk("unexpected_resp", {30'd0, m_ack, m_err}, 32'd0);
         else begin
            mon_e = sbq.pop_front();
            chk("resp_ack", m_ack, mon_e.ack);
            chk("resp_err", m_err, !mon_e.ack);
            if (mon_e.chkdat) chk("rdata", m_dat_o, mon_e.dat);
            if (!mon_e.ack) begin
               chk("err_adr", err_adr, mon_e.eadr);
               chk("err_cnt", err_cnt, mon_e.ecnt);
            end
         end
      end
   end

   typedef struct {
      logic [AW-1:0] adr;
      logic          we;
      logic [DW-1:0] wdat;
      int            waits;
      logic [NS-1:0] spur;
      logic          exp_ack;
      logic [DW-1:0] exp_dat;
      int            exp_lat;
      logic [NS-1:0] exp_stb;
      int            exp_stbc;
   } vec_t;

   function automatic vec_t mk(logic [AW-1:0] adr, logic we, logic [DW-1:0] wd, int w,
                               logic [NS-1:0] sp, logic ack, logic [DW-1:0] d, int lat,
                               logic [NS-1:0] stb, int stbc);
      vec_t v;
      v.adr = adr; v.we = we; v.wdat = wd; v.waits = w; v.spur = sp;
      v.exp_ack = ack; v.exp_dat = d; v.exp_lat = lat; v.exp_stb = stb; v.exp_stbc = stbc;
      return v;
   endfunction

   // Called at a negedge; returns at the negedge after the response cycle.
   task automatic run_req(input vec_t v);
      exp_t          e;
      int            lat = 0, stbc = 0;
      logic          done = 1'b0;
      logic [NS-1:0] stb_or = '0;
      if (!v.exp_ack && mcnt != 8'hFF) mcnt++;
      e.ack = v.exp_ack; e.chkdat = v.exp_ack && !v.we; e.dat = v.exp_dat;
      e.eadr = v.adr; e.ecnt = mcnt;
      sbq.push_back(e);
      slv_wait = v.waits;
      m_adr = v.adr; m_we = v.we; m_dat = v.wdat; m_cyc = 1'b1; m_stb = 1'b1;
      while (!done && lat < 64) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            chk("s_we", s_we, v.we);
            chk("s_dat", s_dat, v.wdat);
            chk("s_adr", s_adr, v.adr[AW-SB-1:0]);
            chk("s_cyc", s_cyc, 1);
            spur = v.spur;
         end
         if (lat == 2) spur = '0;
         if (s_stb != '0) begin stbc++; stb_or |= s_stb; end
         if (m_ack || m_err) done = 1'b1;
      end
      m_cyc = 1'b0; m_stb = 1'b0; spur = '0;
      chk("resp_seen", done, 1);
      chk("latency", lat, v.exp_lat);
      chk("stb_cycles", stbc, v.exp_stbc);
      chk("stb_slot", stb_or, v.exp_stb);
      @(negedge clk);
      chk("resp_one_cycle", {m_ack, m_err}, 0);
   endtask

   vec_t vecs [7];

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: got running expected finished");
      $fatal(1);
   end

   initial begin
      vecs[0] = mk(15'h2005, 0, 16'h0000,  0, 4'b0000, 1, 16'hBEEF,  2, 4'b0010,  1);
      vecs[1] = mk(15'h4010, 1, 16'h1234,  3, 4'b0000, 1, 16'hC2C2,  5, 4'b0100,  4);
      vecs[2] = mk(15'h0003, 0, 16'h0000,  1, 4'b0000, 1, 16'hA0A0,  3, 4'b0001,  2);
      vecs[3] = mk(15'h7FFF, 0, 16'h5555,  2, 4'b0000, 1, 16'hD3D3,  4, 4'b1000,  3);
      vecs[4] = mk(15'h0040, 0, 16'h0000, 14, 4'b0000, 1, 16'hA0A0, 16, 4'b0001, 15);
      vecs[5] = mk(15'h0055, 0, 16'h0000, 15, 4'b0000, 0, 16'h0000, 16, 4'b0001, 15);
      vecs[6] = mk(15'h0100, 0, 16'h0000,  2, 4'b1000, 1, 16'hA0A0,  4, 4'b0001,  3);

      repeat (2) @(negedge clk);
      chk("rst_stb", s_stb, 0);
      chk("rst_ack_err", {m_ack, m_err}, 0);
      chk("rst_dat", m_dat_o, 0);
      chk("rst_err_adr", err_adr, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst3_err_cnt", u3_ecnt, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Unmapped region on the 3-slave instance.
      m_adr = 15'h6123; u3_cyc = 1'b1; u3_stb = 1'b1;
      @(negedge clk);
      chk("u3_err", u3_err, 1);
      chk("u3_ack", u3_ack, 0);
      chk("u3_stb", u3_sstb, 0);
      chk("u3_err_adr", u3_eadr, 15'h6123);
      chk("u3_err_cnt", u3_ecnt, 1);
      u3_cyc = 1'b0; u3_stb = 1'b0;
      @(negedge clk);
      chk("u3_err_clear", u3_err, 0);
      chk("u3_stb_idle", u3_sstb, 0);

      for (int i = 0; i < 7; i++) run_req(vecs[i]);

      // Master abort while the slave is stalled.
      slv_en = 1'b0;
      m_adr = 15'h2000; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_stb_before", s_stb, 4'b0010);
      m_cyc = 1'b0; m_stb = 1'b0;
      @(negedge clk);
      chk("abort_stb_after", s_stb, 0);
      chk("abort_no_resp", {m_ack, m_err}, 0);
      @(negedge clk);
      chk("abort_no_resp2", {m_ack, m_err}, 0);
      slv_en = 1'b1;

      // Abort in the same cycle the slave acks: abort must win.
      slv_wait = 2;
      m_adr = 15'h6000; m_cyc = 1'b1; m_stb = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_ack_stb", s_stb, 4'b1000);
      m_cyc = 1'b0; m_stb = 1'b0;
      @(negedge clk);
      chk("abort_ack_stb_after", s_stb, 0);
      chk("abort_ack_no_resp", {m_ack, m_err}, 0);
      @(negedge clk);
      chk("abort_ack_no_resp2", {m_ack, m_err}, 0);

      run_req(vecs[0]);

      // Error counter saturation through repeated watchdog expiries.
      slv_en = 1'b0;
      for (int i = 0; i < 256; i++)
         run_req(mk(15'h0ABC, 0, 16'h0000, 0, 4'b0000, 0, 16'h0000, 16, 4'b0001, 15));
      chk("err_cnt_saturated", err_cnt, 8'hFF);

      // Reset asserted mid-WAIT.
      m_adr = 15'h4000; m_cyc = 1'b1; m_stb = 1'b1;
      repeat (3) @(negedge clk);
      chk("pre_reset_stb", s_stb, 4'b0100);
      rst_n = 1'b0;
      #1;
      chk("async_rst_stb", s_stb, 0);
      chk("async_rst_cnt", err_cnt, 0);
      chk("async_rst_adr", err_adr, 0);
      chk("async_rst_dat", m_dat_o, 0);
      chk("async_rst_resp", {m_ack, m_err}, 0);
      m_cyc = 1'b0; m_stb = 1'b0; mcnt = '0; slv_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_req(vecs[0]);

      chk("scoreboard_drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
